// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit feeding the architectural HI/LO pair.
// A launch latches operand magnitudes and signs. CALC runs WIDTH shift-add
// multiply steps or WIDTH restoring-divide steps. FIX applies the sign
// correction and writes HI/LO.
//
// Handshake: start is a single-cycle request. It is honoured only while busy is
// low. While busy is high, start, hi_we and lo_we are ignored. done pulses for
// one cycle, and in that same cycle busy is low and hi/lo carry the new result.
module md_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_reg;
  logic               sign_a;
  logic               sign_b;
  logic               div_zero;
  logic [WIDTH-1:0]   a_reg;      // multiplicand magnitude
  logic [WIDTH-1:0]   b_reg;      // divisor magnitude
  logic [2*WIDTH-1:0] acc;        // product accumulator; low half doubles as dividend/quotient
  logic [WIDTH-1:0]   rem;        // committed partial remainder

  // Launch-time operand conditioning.
  logic               is_signed;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  // Per-iteration datapath.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;  // WIDTH+1 bit trial partial remainder
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic               unused_bits;

  // Sign-corrected results presented during FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand magnitudes: signed ops use |x|, so 0x80000000 stays 0x80000000 as unsigned.
  always_comb begin
    is_signed = ~op[0];
    mag_a     = (is_signed && srcA[WIDTH-1]) ? (~srcA + 1'b1) : srcA;
    mag_b     = (is_signed && srcB[WIDTH-1]) ? (~srcB + 1'b1) : srcB;
  end

  // One multiply step (add-then-shift) and one restoring divide step.
  always_comb begin
    mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});
    div_shift   = {rem, acc[WIDTH-1]};
    div_ge      = (div_shift >= {1'b0, b_reg});
    div_diff    = div_shift - {1'b0, b_reg};
    // After a successful subtract the difference is below b_reg, so its top bit is always zero.
    unused_bits = div_diff[WIDTH];
  end

  // Sign correction applied in FIX: product and quotient by sign xor, remainder by dividend sign.
  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
    quo_fix  = (sign_a ^ sign_b) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix  = sign_a ? (~rem + 1'b1) : rem;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: launch, count WIDTH iterations, one fix-up cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == LAST_ITER) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath, HI/LO and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      op_reg   <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      acc      <= '0;
      rem      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // start wins over a same-cycle MTHI/MTLO.
            op_reg   <= op;
            sign_a   <= is_signed & srcA[WIDTH-1];
            sign_b   <= is_signed & srcB[WIDTH-1];
            div_zero <= (srcB == '0);
            a_reg    <= mag_a;
            b_reg    <= mag_b;
            cnt      <= '0;
            rem      <= '0;
            acc      <= op[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (!op_reg[1]) begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end else begin
            rem             <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], div_ge};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (!op_reg[1]) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else begin
            // With a zero divisor the remainder equals |srcA|, so rem_fix restores srcA.
            hi <= rem_fix;
            lo <= div_zero ? {WIDTH{1'b1}} : quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
